// File: rtl/mul_sequencer.sv
// Multi-cycle signed Booth multiplier controller with HI/LO write strobe.
// Define MUL_RADIX4_EN for radix-4 modified Booth (WIDTH/2 steps); default is radix-2 (WIDTH steps).
module mul_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             kill,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mplier,
   output logic             busy,
   output logic             done,
   output logic             hilo_we,
   output logic [WIDTH-1:0] z_low,
   output logic [WIDTH-1:0] z_high
);

   // Two guard bits keep A +/- 2M in range for either radix.
   localparam int unsigned AW = WIDTH + 2;
`ifdef MUL_RADIX4_EN
   localparam int unsigned STEPS = WIDTH / 2;
`else
   localparam int unsigned STEPS = WIDTH;
`endif
   localparam int unsigned CW = $clog2(STEPS + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            busy_d;
   logic            done_d;
   logic            accept_c;
   logic            last_step_c;

   logic [AW-1:0]    acc;
   logic [AW-1:0]    acc_sum;
   logic [AW-1:0]    acc_nxt;
   logic [AW-1:0]    m;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_nxt;
   logic             e;
   logic             e_nxt;
   logic [CW-1:0]    cnt;

   assign accept_c    = start && (state == S_IDLE || state == S_DONE);
   assign last_step_c = (cnt == CW'(1));

   // State register
   always_ff @(posedge clk) begin
      if (clr) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (start) state_nxt = S_RUN;
         S_RUN: begin
            if (kill)             state_nxt = S_IDLE;
            else if (last_step_c) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode of the upcoming state; registered below
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      if (state_nxt == S_RUN)  busy_d = 1'b1;
      if (state_nxt == S_DONE) done_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         hilo_we <= 1'b0;
      end else begin
         busy    <= busy_d;
         done    <= done_d;
         hilo_we <= done_d;
      end
   end

   // One Booth step on {A,Q,E}: add/subtract selected multiple, then arithmetic shift right
`ifdef MUL_RADIX4_EN
   logic [AW-1:0] m2;
   assign m2 = {m[AW-2:0], 1'b0};

   always_comb begin
      acc_sum = acc;
      unique case ({q[1:0], e})
         3'b001, 3'b010: acc_sum = acc + m;
         3'b011:         acc_sum = acc + m2;
         3'b100:         acc_sum = acc - m2;
         3'b101, 3'b110: acc_sum = acc - m;
         default:        acc_sum = acc;
      endcase
      acc_nxt = AW'($signed(acc_sum) >>> 2);
      q_nxt   = {acc_sum[1:0], q[WIDTH-1:2]};
      e_nxt   = q[1];
   end
`else
   always_comb begin
      acc_sum = acc;
      unique case ({q[0], e})
         2'b10:   acc_sum = acc - m;
         2'b01:   acc_sum = acc + m;
         default: acc_sum = acc;
      endcase
      acc_nxt = AW'($signed(acc_sum) >>> 1);
      q_nxt   = {acc_sum[0], q[WIDTH-1:1]};
      e_nxt   = q[0];
   end
`endif

   // Datapath and result registers; result only changes on entry to DONE
   always_ff @(posedge clk) begin
      if (clr) begin
         acc    <= '0;
         q      <= '0;
         e      <= 1'b0;
         m      <= '0;
         cnt    <= '0;
         z_low  <= '0;
         z_high <= '0;
      end else begin
         if (accept_c) begin
            acc <= '0;
            q   <= mplier;
            e   <= 1'b0;
            m   <= {{2{mcand[WIDTH-1]}}, mcand};
            cnt <= CW'(STEPS);
         end else if (state == S_RUN) begin
            acc <= acc_nxt;
            q   <= q_nxt;
            e   <= e_nxt;
            cnt <= cnt - CW'(1);
         end
         if (state == S_RUN && state_nxt == S_DONE) begin
            z_low  <= q_nxt;
            z_high <= acc_nxt[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed table, corner sequences, random vs. arithmetic model.
module tb_mul_sequencer;

   localparam int unsigned W = 32;
`ifdef MUL_RADIX4_EN
   localparam int unsigned N = W / 2;
`else
   localparam int unsigned N = W;
`endif

   logic         clk = 1'b0;
   logic         clr;
   logic         start;
   logic         kill;
   logic [W-1:0] mcand;
   logic [W-1:0] mplier;
   logic         busy;
   logic         done;
   logic         hilo_we;
   logic [W-1:0] z_low;
   logic [W-1:0] z_high;

   int checks = 0;
   int errors = 0;

   mul_sequencer #(.WIDTH(W)) dut (
      .clk    (clk),
      .clr    (clr),
      .start  (start),
      .kill   (kill),
      .mcand  (mcand),
      .mplier (mplier),
      .busy   (busy),
      .done   (done),
      .hilo_we(hilo_we),
      .z_low  (z_low),
      .z_high (z_high)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: exact signed product from plain arithmetic
   function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      longint pa;
      longint pb;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
   endfunction

   // Start at next edge, check busy window, done timing and product
   task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp);
      int bad;
      bad = 0;
      @(negedge clk);
      mcand  = a;
      mplier = b;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= int'(N); i++) begin
         if (busy !== 1'b1 || done !== 1'b0 || hilo_we !== 1'b0) bad++;
         @(negedge clk);
      end
      chk({name, " busy_window"}, 64'(bad), 64'd0);
      chk({name, " done/we/busy"}, {61'd0, done, hilo_we, busy}, 64'b110);
      chk({name, " product"}, {z_high, z_low}, exp);
      @(negedge clk);
      chk({name, " done_pulse_end"}, {62'd0, done, hilo_we}, 64'd0);
   endtask

   vec_t         tbl[8];
   logic [63:0]  last;
   int           cnt_done;

   initial begin
      tbl[0] = '{32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      tbl[1] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      tbl[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
      tbl[3] = '{32'd5,        32'd6,         32'h0,         32'h1E};
      tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1};
      tbl[5] = '{32'hFFFF_FFF8, 32'd8,         32'hFFFF_FFFF, 32'hFFFF_FFC0};
      tbl[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000};
      tbl[7] = '{32'd0,        32'h8000_0000, 32'h0,         32'h0};

      clr = 1'b1; start = 1'b0; kill = 1'b0; mcand = '0; mplier = '0;
      repeat (2) @(negedge clk);
      chk("reset outputs", {29'd0, busy, done, hilo_we, z_high, z_low}, 64'd0);
      clr = 1'b0;
      cnt_done = 0;
      repeat (10) begin
         @(negedge clk);
         if (done || busy) cnt_done++;
      end
      chk("idle no activity", 64'(cnt_done), 64'd0);

      // Directed table
      for (int i = 0; i < 8; i++)
         run_mul($sformatf("table%0d", i), tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo});

      // Back-to-back with start held high throughout RUN
      @(negedge clk);
      mcand = 32'd5; mplier = 32'd6; start = 1'b1;
      cnt_done = 0;
      for (int i = 1; i <= int'(N); i++) begin
         @(negedge clk);
         if (done) cnt_done++;
      end
      @(negedge clk);
      chk("b2b first done", {63'd0, done}, 64'd1);
      chk("b2b first product", {z_high, z_low}, 64'h1E);
      mcand = 32'hFFFF_FFFF; mplier = 32'hFFFF_FFFF;
      for (int i = 1; i <= int'(N); i++) begin
         @(negedge clk);
         if (done || !busy) cnt_done++;
      end
      @(negedge clk);
      start = 1'b0;
      chk("b2b no extra done", 64'(cnt_done), 64'd0);
      chk("b2b second done", {63'd0, done}, 64'd1);
      chk("b2b second product", {z_high, z_low}, 64'h1);
      @(negedge clk);
      chk("b2b back to idle", {62'd0, busy, done}, 64'd0);

      // Kill at RUN cycle 10
      run_mul("pre-kill", 32'd100, 32'd100, 64'h2710);
      @(negedge clk);
      mcand = 32'd2; mplier = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) begin
         @(negedge clk);
         start = ~start;
      end
      start = 1'b0;
      kill  = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill idle", {62'd0, busy, done}, 64'd0);
      cnt_done = 0;
      repeat (N + 4) begin
         @(negedge clk);
         if (done || busy) cnt_done++;
      end
      chk("kill no done", 64'(cnt_done), 64'd0);
      chk("kill keeps result", {z_high, z_low}, 64'h2710);
      run_mul("post-kill", 32'd2, 32'd3, 64'h6);

      // Clear at RUN cycle 5
      @(negedge clk);
      mcand = 32'd11; mplier = 32'd13; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr mid-op", {29'd0, busy, done, hilo_we, z_high, z_low}, 64'd0);
      run_mul("post-clr", 32'hFFFF_FFF8, 32'd8, 64'hFFFF_FFFF_FFFF_FFC0);

      // Random operands against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = $urandom;
         rb = $urandom;
         if (i % 8 == 3) ra = W'($urandom_range(0, 15)) - W'(8);
         last = ref_mul(ra, rb);
         run_mul($sformatf("rand%0d", i), ra, rb, last);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
